pulp_jtag_cfg_tap: RTL and testbench
====================================

// Module: pulp_jtag_cfg_tap
// PURPOSE
//  Parametrised PULP JTAG test access port: IEEE 1149.1 TAP FSM, an IR and NUM_REGS configuration DRs plus IDCODE, BYPASS and DBG chains.
//  Sits at chip top between the JTAG pads and the SoC. Config DRs drive SoC control bits; capture samples synchronised SoC status.
//  Successor of the single-confreg TAP wrapper: N registers of width REG_WIDTH, per-register update strobes and an IDCODE DR.
// PARAMETERS
//  IR_WIDTH     5             instruction register width (>= 4)
//  NUM_REGS     2             number of configuration DRs (1..8)
//  REG_WIDTH    9             bits per configuration DR (1..32)
//  SYNC_STAGES  2             soc_reg_i synchroniser depth into tck (>= 2)
//  IDCODE_VAL   32'h249511C3  IDCODE value; bit 0 must be 1
// PORTS
//  tck_i          in   1                   JTAG clock
//  trst_ni        in   1                   JTAG reset, asynchronous, active-low
//  tms_i          in   1                   test mode select, sampled on posedge tck
//  td_i           in   1                   test data in, sampled on posedge tck
//  td_o           out  1                   test data out, updated on negedge tck
//  tdo_oe_o       out  1                   1 while in Shift-IR/Shift-DR (negedge-registered)
//  soc_reg_i      in   NUM_REGS*REG_WIDTH  SoC status, async to tck; captured into the selected DR
//  soc_reg_o      out  NUM_REGS*REG_WIDTH  configuration outputs, tck domain
//  soc_reg_upd_o  out  NUM_REGS            1-cycle pulse when DR i is updated
//  dbg_sel_o      out  1                   IR == DBG (external debug chain selected)
//  shift_dr_o     out  1                   FSM in Shift-DR
//  capture_dr_o   out  1                   FSM in Capture-DR
//  update_dr_o    out  1                   FSM in Update-DR
//  dbg_scan_in_o  out  1                   td_i forwarded to the external chain
//  dbg_scan_out_i in   1                   external chain serial output
// BEHAVIOUR
//  - FSM: the 16 standard TAP states. Transitions on posedge tck from tms_i.
//  - trst_ni low: FSM=Test-Logic-Reset, IR=IDCODE, soc_reg_o=0, soc_reg_upd_o=0, td_o=0, tdo_oe_o=0, all syncs=0.
//  - 5 consecutive TMS=1 reach Test-Logic-Reset from any state. That state forces IR=IDCODE; soc_reg_o keeps its value.
//  - Opcodes: IDCODE=1, DBG=4, CFG_i=8+i, BYPASS=all-ones. Any other value behaves as BYPASS.
//  - Capture-IR loads 'b0..01. Shift-IR is LSB-first, td_i enters at the MSB. Update-IR commits the shift register to IR.
//  - Capture-DR:
//      IDCODE loads IDCODE_VAL. BYPASS loads 0.
//      CFG_i loads sync(soc_reg_i[i]), the last SYNC_STAGES-deep value.
//  - Shift-DR: the selected DR shifts right, LSB out, td_i enters at the MSB.
//  - Update-DR with CFG_i: soc_reg_o[i] <= shift register. soc_reg_upd_o[i] pulses for exactly the Update-DR cycle.
//  - Update-DR with any other IR leaves soc_reg_o unchanged.
//  - DR lengths: IDCODE 32, BYPASS 1, CFG_i REG_WIDTH. DBG length is external.
//  - Aborting a shift (Exit1 -> Update without a full shift) commits the partially shifted value. This is standard; no special handling.
//  - td_o source mux by state/IR: IR shift LSB, selected DR LSB, or dbg_scan_out_i (IR==DBG). Registered on negedge tck.
//  - td_o = 0 outside shift states.
//  - shift/capture/update_dr_o are decoded from the state irrespective of IR; external chains qualify them with dbg_sel_o.
//  - Reset asserted mid-shift aborts the shift; no update pulse is produced.
// CONFIGURATION
//  - PULP_JTAG_CFG_MASK_EN defined: adds parameter CFG_WR_MASK [NUM_REGS*REG_WIDTH], default all-ones.
//      On Update-DR, soc_reg_o bits whose mask bit is 0 keep their value.
//      Those bits still capture and shift normally (read-only).
//  - PULP_JTAG_CFG_MASK_EN undefined: every bit is writable. No mask parameter exists.
// STRUCTURE
//  - Package pulp_jtag_pkg:
//      tap_state_e enum (16 states).
//      Opcode constants IR_IDCODE, IR_DBG, IR_CFG_BASE, IR_BYPASS.
//      Function next_state(tap_state_e, logic tms).
//  - Sub-module pulp_jtag_tap_fsm:
//      Inputs tck, trst_ni, tms. Outputs state plus one-hot decodes (capture/shift/update for IR and DR, test_logic_reset).
//  - Top keeps the IR, DR shift registers, sync flops, td_o mux and output regs.
// TESTING
//  1. Reset, TMS 0,1,0,0 (Shift-DR), shift 32 -> td_o yields 0x249511C3 LSB-first.
//  2. Load IR=BYPASS, shift 8'hA5 through Shift-DR -> the same pattern appears on td_o delayed by 1 tck.
//  3. IR=CFG_1 (9), shift 9'h1A5, Update-DR -> soc_reg_o[1]=0x1A5, soc_reg_upd_o=2'b10 for 1 cycle, soc_reg_o[0] unchanged.
//  4. soc_reg_i[0]=0x0F3 stable 2 tck, IR=CFG_0, Capture-DR then shift -> td_o reads 0x0F3. A change 1 tck before capture reads the old value.
//  5. IR=DBG: dbg_sel_o=1, dbg_scan_in_o follows td_i, td_o mirrors dbg_scan_out_i a half-cycle later. 5xTMS=1 -> dbg_sel_o=0, IR=IDCODE.
//  6. trst_ni low mid Shift-DR of CFG_0 -> no upd pulse, soc_reg_o=0, td_o=0. With MASK_EN and mask 0x0FF, writing 0x1FF changes only bits 7:0.

Source files
------------

// File: rtl/pulp_jtag_pkg.sv
// Shared types and constants for the PULP JTAG configuration TAP.
package pulp_jtag_pkg;

  typedef enum logic [3:0] {
    TEST_LOGIC_RESET,
    RUN_TEST_IDLE,
    SELECT_DR_SCAN,
    CAPTURE_DR,
    SHIFT_DR,
    EXIT1_DR,
    PAUSE_DR,
    EXIT2_DR,
    UPDATE_DR,
    SELECT_IR_SCAN,
    CAPTURE_IR,
    SHIFT_IR,
    EXIT1_IR,
    PAUSE_IR,
    EXIT2_IR,
    UPDATE_IR
  } tap_state_e;

  localparam int unsigned IR_IDCODE   = 1;
  localparam int unsigned IR_DBG      = 4;
  localparam int unsigned IR_CFG_BASE = 8;
  // All-ones opcode; truncated to the instruction register width at use.
  localparam logic [31:0] IR_BYPASS   = '1;

  // IEEE 1149.1 TAP controller transition function.
  function automatic tap_state_e next_state(tap_state_e s, logic tms);
    tap_state_e n;
    case (s)
      TEST_LOGIC_RESET: n = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    n = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_DR_SCAN:   n = tms ? SELECT_IR_SCAN   : CAPTURE_DR;
      CAPTURE_DR:       n = tms ? EXIT1_DR         : SHIFT_DR;
      SHIFT_DR:         n = tms ? EXIT1_DR         : SHIFT_DR;
      EXIT1_DR:         n = tms ? UPDATE_DR        : PAUSE_DR;
      PAUSE_DR:         n = tms ? EXIT2_DR         : PAUSE_DR;
      EXIT2_DR:         n = tms ? UPDATE_DR        : SHIFT_DR;
      UPDATE_DR:        n = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_IR_SCAN:   n = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       n = tms ? EXIT1_IR         : SHIFT_IR;
      SHIFT_IR:         n = tms ? EXIT1_IR         : SHIFT_IR;
      EXIT1_IR:         n = tms ? UPDATE_IR        : PAUSE_IR;
      PAUSE_IR:         n = tms ? EXIT2_IR         : PAUSE_IR;
      EXIT2_IR:         n = tms ? UPDATE_IR        : SHIFT_IR;
      UPDATE_IR:        n = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      default:          n = TEST_LOGIC_RESET;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/pulp_jtag_tap_fsm.sv
// TAP controller state machine with registered one-hot state decodes.
module pulp_jtag_tap_fsm
  import pulp_jtag_pkg::*;
(
  input  logic       tck,
  input  logic       trst_ni,
  input  logic       tms,
  output tap_state_e state,
  output logic       test_logic_reset,
  output logic       capture_dr,
  output logic       shift_dr,
  output logic       update_dr,
  output logic       capture_ir,
  output logic       shift_ir,
  output logic       update_ir
);

  tap_state_e nxt;

  // Next state from the current state and TMS.
  always_comb begin
    nxt = next_state(state, tms);
  end

  // State register; decodes are registered from the next state so they align with state.
  always_ff @(posedge tck or negedge trst_ni) begin
    if (!trst_ni) begin
      state            <= TEST_LOGIC_RESET;
      test_logic_reset <= 1'b1;
      capture_dr       <= 1'b0;
      shift_dr         <= 1'b0;
      update_dr        <= 1'b0;
      capture_ir       <= 1'b0;
      shift_ir         <= 1'b0;
      update_ir        <= 1'b0;
    end else begin
      state            <= nxt;
      test_logic_reset <= (nxt == TEST_LOGIC_RESET);
      capture_dr       <= (nxt == CAPTURE_DR);
      shift_dr         <= (nxt == SHIFT_DR);
      update_dr        <= (nxt == UPDATE_DR);
      capture_ir       <= (nxt == CAPTURE_IR);
      shift_ir         <= (nxt == SHIFT_IR);
      update_ir        <= (nxt == UPDATE_IR);
    end
  end

endmodule

// File: rtl/pulp_jtag_cfg_tap.sv
// PULP JTAG TAP: IR, IDCODE/BYPASS/DBG selection and NUM_REGS configuration DRs.
// Optional write mask on the configuration outputs: define PULP_JTAG_CFG_MASK_EN.
module pulp_jtag_cfg_tap
  import pulp_jtag_pkg::*;
#(
  parameter int unsigned IR_WIDTH    = 5,
  parameter int unsigned NUM_REGS    = 2,
  parameter int unsigned REG_WIDTH   = 9,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [31:0] IDCODE_VAL  = 32'h249511C3
`ifdef PULP_JTAG_CFG_MASK_EN
  ,
  parameter logic [NUM_REGS*REG_WIDTH-1:0] CFG_WR_MASK = '1
`endif
) (
  input  logic                          tck_i,
  input  logic                          trst_ni,
  input  logic                          tms_i,
  input  logic                          td_i,
  output logic                          td_o,
  output logic                          tdo_oe_o,
  input  logic [NUM_REGS*REG_WIDTH-1:0] soc_reg_i,
  output logic [NUM_REGS*REG_WIDTH-1:0] soc_reg_o,
  output logic [NUM_REGS-1:0]           soc_reg_upd_o,
  output logic                          dbg_sel_o,
  output logic                          shift_dr_o,
  output logic                          capture_dr_o,
  output logic                          update_dr_o,
  output logic                          dbg_scan_in_o,
  input  logic                          dbg_scan_out_i
);

  localparam int unsigned SOC_W = NUM_REGS * REG_WIDTH;

  tap_state_e state;
  logic test_logic_reset, capture_dr, shift_dr, update_dr;
  logic capture_ir, shift_ir, update_ir;

  logic [IR_WIDTH-1:0] ir, ir_shift;
  logic                sel_idcode, sel_dbg, sel_bypass;
  logic [NUM_REGS-1:0] sel_cfg;
  logic [SOC_W-1:0]    sync_q [SYNC_STAGES];
  logic [31:0]         dr, dr_next, dr_cap;

  pulp_jtag_tap_fsm u_fsm (
    .tck              (tck_i),
    .trst_ni          (trst_ni),
    .tms              (tms_i),
    .state            (state),
    .test_logic_reset (test_logic_reset),
    .capture_dr       (capture_dr),
    .shift_dr         (shift_dr),
    .update_dr        (update_dr),
    .capture_ir       (capture_ir),
    .shift_ir         (shift_ir),
    .update_ir        (update_ir)
  );

  // Instruction decode; unknown opcodes fall through to BYPASS.
  always_comb begin
    sel_idcode = (ir == IR_WIDTH'(IR_IDCODE));
    sel_dbg    = (ir == IR_WIDTH'(IR_DBG));
    sel_cfg    = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      sel_cfg[i] = (ir == IR_WIDTH'(IR_CFG_BASE + i));
    end
    sel_bypass = (ir == IR_WIDTH'(IR_BYPASS)) || !(sel_idcode || sel_dbg || (|sel_cfg));
  end

  // Instruction register and its shift stage; Test-Logic-Reset forces IDCODE.
  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      ir       <= IR_WIDTH'(IR_IDCODE);
      ir_shift <= '0;
    end else begin
      if (test_logic_reset) begin
        ir <= IR_WIDTH'(IR_IDCODE);
      end else if (update_ir) begin
        ir <= ir_shift;
      end
      if (capture_ir) begin
        ir_shift <= IR_WIDTH'(1);
      end else if (shift_ir) begin
        ir_shift <= {td_i, ir_shift[IR_WIDTH-1:1]};
      end
    end
  end

  // SoC status synchroniser into the tck domain.
  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= soc_reg_i;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  // One shared 32-bit DR; td_i enters at the top of the selected register's length.
  always_comb begin
    dr_next = dr >> 1;
    dr_cap  = '0;
    if (sel_idcode) begin
      dr_next[31] = td_i;
      dr_cap      = IDCODE_VAL;
    end else if (|sel_cfg) begin
      dr_next[REG_WIDTH-1] = td_i;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (sel_cfg[i]) begin
          dr_cap[REG_WIDTH-1:0] = sync_q[SYNC_STAGES-1][i*REG_WIDTH +: REG_WIDTH];
        end
      end
    end else if (sel_bypass) begin
      dr_next[0] = td_i;
    end else begin
      dr_next[0] = td_i;
    end
  end

  // DR capture and shift.
  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      dr <= '0;
    end else if (capture_dr) begin
      dr <= dr_cap;
    end else if (shift_dr) begin
      dr <= dr_next;
    end
  end

  // Configuration outputs, written from the DR on Update-DR of the selected CFG register.
  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      soc_reg_o <= '0;
    end else if (update_dr) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (sel_cfg[i]) begin
`ifdef PULP_JTAG_CFG_MASK_EN
          soc_reg_o[i*REG_WIDTH +: REG_WIDTH] <=
            (soc_reg_o[i*REG_WIDTH +: REG_WIDTH] & ~CFG_WR_MASK[i*REG_WIDTH +: REG_WIDTH]) |
            (dr[REG_WIDTH-1:0] & CFG_WR_MASK[i*REG_WIDTH +: REG_WIDTH]);
`else
          soc_reg_o[i*REG_WIDTH +: REG_WIDTH] <= dr[REG_WIDTH-1:0];
`endif
        end
      end
    end
  end

  // Serial output and enable, launched on the falling edge of tck.
  always_ff @(negedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      td_o     <= 1'b0;
      tdo_oe_o <= 1'b0;
    end else begin
      tdo_oe_o <= (state == SHIFT_IR) || (state == SHIFT_DR);
      if (shift_ir) begin
        td_o <= ir_shift[0];
      end else if (shift_dr) begin
        td_o <= sel_dbg ? dbg_scan_out_i : dr[0];
      end else begin
        td_o <= 1'b0;
      end
    end
  end

  assign soc_reg_upd_o = sel_cfg & {NUM_REGS{update_dr}};
  assign dbg_sel_o     = sel_dbg;
  assign shift_dr_o    = shift_dr;
  assign capture_dr_o  = capture_dr;
  assign update_dr_o   = update_dr;
  assign dbg_scan_in_o = td_i;

endmodule

// File: tb/tb_pulp_jtag_cfg_tap.sv
// Directed bench for pulp_jtag_cfg_tap (default parameters: IR 5, 2 x 9-bit CFG DRs).
module tb_pulp_jtag_cfg_tap;

  localparam int unsigned SW = 18;

  logic          tck_i = 1'b0;
  logic          trst_ni = 1'b0;
  logic          tms_i = 1'b1;
  logic          td_i = 1'b0;
  logic          dbg_scan_out_i = 1'b0;
  logic [SW-1:0] soc_reg_i = '0;
  logic          td_o, tdo_oe_o, dbg_sel_o, shift_dr_o, capture_dr_o, update_dr_o, dbg_scan_in_o;
  logic [SW-1:0] soc_reg_o;
  logic [1:0]    soc_reg_upd_o;

  int checks = 0;
  int errors = 0;

  always #5 tck_i = ~tck_i;

  pulp_jtag_cfg_tap #(
    .IR_WIDTH    (5),
    .NUM_REGS    (2),
    .REG_WIDTH   (9),
    .SYNC_STAGES (2),
    .IDCODE_VAL  (32'h249511C3)
`ifdef PULP_JTAG_CFG_MASK_EN
    ,
    .CFG_WR_MASK (18'h3FEFF)
`endif
  ) dut (
    .tck_i          (tck_i),
    .trst_ni        (trst_ni),
    .tms_i          (tms_i),
    .td_i           (td_i),
    .td_o           (td_o),
    .tdo_oe_o       (tdo_oe_o),
    .soc_reg_i      (soc_reg_i),
    .soc_reg_o      (soc_reg_o),
    .soc_reg_upd_o  (soc_reg_upd_o),
    .dbg_sel_o      (dbg_sel_o),
    .shift_dr_o     (shift_dr_o),
    .capture_dr_o   (capture_dr_o),
    .update_dr_o    (update_dr_o),
    .dbg_scan_in_o  (dbg_scan_in_o),
    .dbg_scan_out_i (dbg_scan_out_i)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One tck: sample td_o after the falling edge, drive TMS/TDI, step past the rising edge.
  task automatic tick(input logic tms, input logic tdi, output logic tdo);
    @(negedge tck_i);
    #1;
    tdo   = td_o;
    tms_i = tms;
    td_i  = tdi;
    @(posedge tck_i);
    #1;
  endtask

  task automatic move(input logic tms);
    logic d;
    tick(tms, 1'b0, d);
  endtask

  // Shift n bits LSB-first, TMS=1 on the last bit (ends in Exit1).
  task automatic scan(input int n, input logic [31:0] din, output logic [31:0] dout);
    logic b;
    dout = '0;
    for (int k = 0; k < n; k++) begin
      tick(k == n - 1, din[k], b);
      dout[k] = b;
    end
  endtask

  // From Run-Test/Idle: load an instruction and return to Run-Test/Idle.
  task automatic load_ir(input logic [31:0] op, output logic [31:0] cap);
    move(1'b1); move(1'b1); move(1'b0); move(1'b0);
    scan(5, op, cap);
    move(1'b1); move(1'b0);
  endtask

  task automatic to_shift_dr();
    move(1'b1); move(1'b0); move(1'b0);
  endtask

  task automatic finish_dr();
    move(1'b1); move(1'b0);
  endtask

  initial begin
    logic [31:0] d, cap;
    logic [3:0]  pat;
    logic        b;

    // Reset state
    repeat (2) @(posedge tck_i);
    #1;
    check("rst_soc_reg", 32'(soc_reg_o), 32'h0);
    check("rst_upd", 32'(soc_reg_upd_o), 32'h0);
    check("rst_td_o", 32'(td_o), 32'h0);
    check("rst_tdo_oe", 32'(tdo_oe_o), 32'h0);
    check("rst_dbg_sel", 32'(dbg_sel_o), 32'h0);
    trst_ni = 1'b1;

    // 1. IDCODE after reset
    move(1'b0);
    move(1'b1); move(1'b0);
    check("capture_dr_o", 32'(capture_dr_o), 32'h1);
    move(1'b0);
    check("shift_dr_o", 32'(shift_dr_o), 32'h1);
    scan(32, 32'h0, d);
    check("idcode", d, 32'h249511C3);
    finish_dr();

    // 2. BYPASS: one-bit delay
    load_ir(32'h1F, cap);
    check("ir_capture", cap, 32'h1);
    to_shift_dr();
    scan(9, 32'h0A5, d);
    check("bypass", d, 32'h14A);
    finish_dr();

    // 3. CFG_1 write
    soc_reg_i = {9'h055, 9'h000};
    load_ir(32'd9, cap);
    to_shift_dr();
    scan(9, 32'h1A5, d);
    check("cfg1_capture", d, 32'h055);
    move(1'b1);
    check("cfg1_upd_pulse", 32'(soc_reg_upd_o), 32'h2);
    check("update_dr_o", 32'(update_dr_o), 32'h1);
    move(1'b0);
    check("cfg1_upd_after", 32'(soc_reg_upd_o), 32'h0);
    check("cfg1_soc_reg", 32'(soc_reg_o), 32'h34A00);

    // 4. CFG_0 capture through the synchroniser
    soc_reg_i = {9'h055, 9'h0F3};
    load_ir(32'd8, cap);
    move(1'b1);
    soc_reg_i = {9'h055, 9'h10C};
    move(1'b0); move(1'b0);
    scan(9, 32'h0, d);
    check("cfg0_capture_old", d, 32'h0F3);
    finish_dr();
    to_shift_dr();
    scan(9, 32'h0, d);
    check("cfg0_capture_new", d, 32'h10C);
    finish_dr();
    check("cfg0_soc_reg", 32'(soc_reg_o), 32'h34A00);

    // 5. DBG chain pass-through, then Test-Logic-Reset
    load_ir(32'd4, cap);
    check("dbg_sel", 32'(dbg_sel_o), 32'h1);
    td_i = 1'b1; #1;
    check("dbg_scan_in_1", 32'(dbg_scan_in_o), 32'h1);
    td_i = 1'b0; #1;
    check("dbg_scan_in_0", 32'(dbg_scan_in_o), 32'h0);
    to_shift_dr();
    pat = 4'b1011;
    d = '0;
    for (int k = 0; k < 4; k++) begin
      dbg_scan_out_i = pat[k];
      tick(k == 3, 1'b0, b);
      d[k] = b;
    end
    dbg_scan_out_i = 1'b0;
    check("dbg_td_o", d, 32'hB);
    check("tdo_oe_shift", 32'(tdo_oe_o), 32'h1);
    finish_dr();
    repeat (5) move(1'b1);
    check("tlr_dbg_sel", 32'(dbg_sel_o), 32'h0);
    check("tlr_soc_reg_kept", 32'(soc_reg_o), 32'h34A00);
    move(1'b0);
    to_shift_dr();
    scan(32, 32'h0, d);
    check("tlr_ir_idcode", d, 32'h249511C3);
    finish_dr();

    // 6. Reset during a CFG_0 shift, then masked write
    load_ir(32'd8, cap);
    to_shift_dr();
    repeat (4) tick(1'b0, 1'b1, b);
    trst_ni = 1'b0;
    #1;
    check("mid_rst_upd", 32'(soc_reg_upd_o), 32'h0);
    check("mid_rst_soc_reg", 32'(soc_reg_o), 32'h0);
    check("mid_rst_td_o", 32'(td_o), 32'h0);
    check("mid_rst_shift_dr", 32'(shift_dr_o), 32'h0);
    #3;
    trst_ni = 1'b1;
    tms_i = 1'b1;
    move(1'b0);
    load_ir(32'd8, cap);
    to_shift_dr();
    scan(9, 32'h1FF, d);
    check("cfg0_recapture", d, 32'h10C);
    finish_dr();
`ifdef PULP_JTAG_CFG_MASK_EN
    check("mask_write", 32'(soc_reg_o), 32'h000FF);
`else
    check("full_write", 32'(soc_reg_o), 32'h001FF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion expected completion by 200000");
    $fatal(1, "simulation time limit");
  end

endmodule
